// File: rtl/message_schedule_gen.sv
// message_schedule_gen: SHA-256 message schedule expander.
// Loads a 512-bit padded block as W0..W15, then expands W16..W63 at
// EXP_PER_CYCLE words per cycle. The full 64-word schedule is held stable
// for the compression stage until it is taken.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   block_in[0:511]   - padded block, bit 0 is the MSB of W0
//   in_valid/in_ready - block input handshake
//   message_schedule  - W0..W63, each word [0:31] with bit 0 as MSB
//   out_valid/out_ready - schedule output handshake

package sigma_functions;

  // SHA-256 lower-case sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0_lower(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // SHA-256 lower-case sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1_lower(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

module message_schedule_gen #(
  parameter int unsigned EXP_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:511] block_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:31]  message_schedule [0:63],
  output logic         out_valid,
  input  logic         out_ready
);

  import sigma_functions::*;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned NUM_WORDS   = 64;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned CNT_W       = 7;
  localparam int unsigned IDX_W       = 6;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_step;
  logic               accept;
  logic [WORD_W-1:0]  w_q    [0:NUM_WORDS-1];
  logic [WORD_W-1:0]  w_next [0:NUM_WORDS-1];

  // Downstream handoff in DONE frees the slot on the same edge.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_step = cnt + CNT_W'(EXP_PER_CYCLE);

  // Expansion is chained through w_next so later words in the same cycle
  // see the freshly computed earlier words rather than stale registers.
  always_comb begin
    logic [IDX_W-1:0] t;
    w_next = w_q;
    t      = '0;
    for (int k = 0; k < int'(EXP_PER_CYCLE); k++) begin
      t = IDX_W'(cnt + CNT_W'(k));
      w_next[t] = sigma1_lower(w_next[t - IDX_W'(2)])
                + w_next[t - IDX_W'(7)]
                + sigma0_lower(w_next[t - IDX_W'(15)])
                + w_next[t - IDX_W'(16)];
    end
  end

  // Output view of the schedule registers.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_out
    assign message_schedule[g] = w_q[g];
  end

  // State, counter, schedule registers and out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        w_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
        w_q[i] <= block_in[WORD_W*i +: WORD_W];
      end
      cnt       <= CNT_W'(BLOCK_WORDS);
      state     <= EXPAND;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EXPAND: begin
          w_q <= w_next;
          cnt <= cnt_step;
          if (cnt_step == CNT_W'(NUM_WORDS)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_message_schedule_gen.sv
// tb_message_schedule_gen: directed bench for message_schedule_gen.
// dut_a runs one word per cycle, dut_b four words per cycle; both are
// compared against a bench-side SHA-256 schedule model.

module tb_message_schedule_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:511] blk_a, blk_b, abc_blk, zero_blk;
  logic         iv_a, iv_b, ir_a, ir_b, ov_a, ov_b, or_a, or_b;
  logic [0:31]  ms_a [0:63];
  logic [0:31]  ms_b [0:63];
  logic [31:0]  exp_w [0:63];
  logic [31:0]  snap [0:63];
  int           errors = 0;
  int           checks = 0;
  int           lat_a, lat_b, diff, stray;

  message_schedule_gen #(.EXP_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst), .block_in(blk_a), .in_valid(iv_a), .in_ready(ir_a),
    .message_schedule(ms_a), .out_valid(ov_a), .out_ready(or_a)
  );

  message_schedule_gen #(.EXP_PER_CYCLE(4)) dut_b (
    .clk(clk), .rst(rst), .block_in(blk_b), .in_valid(iv_b), .in_ready(ir_b),
    .message_schedule(ms_b), .out_valid(ov_b), .out_ready(or_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule for a block, written into exp_w.
  task automatic build_ref(input logic [0:511] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = blk[32*i +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b0; or_b = 1'b0;
    zero_blk = '0;
    abc_blk = '0;
    abc_blk[0:31]    = 32'h61626380;
    abc_blk[480:511] = 32'h00000018;
    blk_a = zero_blk; blk_b = zero_blk;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(ov_a), 32'd0);
    check("rst_in_ready",  32'(ir_a), 32'd1);
    check("rst_w0",  ms_a[0],  32'd0);
    check("rst_w63", ms_a[63], 32'd0);
    rst = 1'b0;
    tick();

    // "abc" into both instances on the same accept edge
    build_ref(abc_blk);
    blk_a = abc_blk; blk_b = abc_blk; iv_a = 1'b1; iv_b = 1'b1;
    tick();
    iv_a = 1'b0; iv_b = 1'b0;
    check("expand_in_ready",  32'(ir_a), 32'd0);
    check("expand_out_valid", 32'(ov_a), 32'd0);

    lat_a = 0; lat_b = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin iv_a = 1'b1; blk_a = '1; end
      if (n == 8) begin iv_a = 1'b0; blk_a = zero_blk; end
      tick();
      if (n == 6) check("ignore_in_ready", 32'(ir_a), 32'd0);
      if (ov_a && lat_a == 0) lat_a = n;
      if (ov_b && lat_b == 0) lat_b = n;
    end
    check("abc_latency_x1", 32'(lat_a), 32'd48);
    check("abc_latency_x4", 32'(lat_b), 32'd12);

    check("abc_w16", ms_a[16], 32'h61626380);
    check("abc_w17", ms_a[17], 32'h000F0000);
    check("abc_w18", ms_a[18], 32'h7DA86405);
    check("abc_w19", ms_a[19], 32'h600003C6);
    check("abc_x4_w17", ms_b[17], 32'h000F0000);
    check("abc_x4_w19", ms_b[19], 32'h600003C6);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("abc_x1_w%0d", i), ms_a[i], exp_w[i]);
      check($sformatf("abc_x4_w%0d", i), ms_b[i], exp_w[i]);
    end

    // Backpressure with an ignored in_valid in DONE
    for (int i = 0; i < 64; i++) snap[i] = ms_a[i];
    blk_a = zero_blk; iv_a = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      diff = 0;
      for (int i = 0; i < 64; i++) if (ms_a[i] !== snap[i]) diff++;
      check($sformatf("bp_out_valid_%0d", n), 32'(ov_a), 32'd1);
      check($sformatf("bp_in_ready_%0d", n),  32'(ir_a), 32'd0);
      check($sformatf("bp_stable_%0d", n),    32'(diff), 32'd0);
    end

    // Back-to-back: handoff and all-zero block accept on the same edge
    build_ref(zero_blk);
    or_a = 1'b1;
    #1;
    check("b2b_in_ready", 32'(ir_a), 32'd1);
    tick();
    or_a = 1'b0; iv_a = 1'b0;
    check("b2b_out_valid", 32'(ov_a), 32'd0);
    check("b2b_in_ready_after", 32'(ir_a), 32'd0);
    lat_a = 0;
    for (int n = 1; n <= 60 && lat_a == 0; n++) begin
      tick();
      if (ov_a) lat_a = n;
    end
    check("zero_latency", 32'(lat_a), 32'd48);
    check("zero_w63", ms_a[63], 32'd0);
    for (int i = 16; i < 64; i++) check($sformatf("zero_w%0d", i), ms_a[i], exp_w[i]);

    // Handoff without a new block returns to IDLE; out_ready then has no effect
    or_a = 1'b1;
    tick();
    check("handoff_out_valid", 32'(ov_a), 32'd0);
    check("handoff_in_ready",  32'(ir_a), 32'd1);
    tick();
    check("idle_out_ready_noeffect", 32'(ov_a), 32'd0);
    or_a = 1'b0;

    // Reset pulse 20 cycles into EXPAND
    blk_a = abc_blk; iv_a = 1'b1;
    tick();
    iv_a = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    diff = 0;
    for (int i = 0; i < 64; i++) if (ms_a[i] !== 32'd0) diff++;
    check("rst_mid_out_valid",  32'(ov_a), 32'd0);
    check("rst_mid_in_ready",   32'(ir_a), 32'd1);
    check("rst_mid_words_zero", 32'(diff), 32'd0);
    check("rst_mid_x4_out_valid", 32'(ov_b), 32'd0);
    tick(); tick();
    rst = 1'b0;
    stray = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (ov_a) stray++;
    end
    check("post_rst_stray_valid", 32'(stray), 32'd0);
    check("post_rst_in_ready", 32'(ir_a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/message_schedule_gen.md
MESSAGE_SCHEDULE_GEN -- requirements
Module: message_schedule_gen

Interface
REQ-001 SHALL have parameter EXP_PER_CYCLE, default 1: schedule words computed per EXPAND cycle; legal values 1, 2, 3, 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port block_in, input, 512 bits [0:511]: padded message block; bits [0:31] are W0, bits [480:511] are W15; bit 0 is the MSB of W0.
REQ-005 SHALL have port in_valid, input, 1 bit: block_in is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept block_in this cycle.
REQ-007 SHALL have port message_schedule, output, 64 x 32 bits [0:31] each, indexed [0:63]: the expanded schedule W0..W63, which feeds the compression stage directly.
REQ-008 SHALL have port out_valid, output, 1 bit: message_schedule is complete and stable.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream stage takes the schedule this cycle.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, EXPAND, DONE.
REQ-011 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-012 SHALL accept a block on any rising edge where in_valid and in_ready are both 1; this is the accept edge.
REQ-013 On the accept edge, SHALL load W0..W15 from block_in, set the index counter to 16, and enter EXPAND.
REQ-014 In EXPAND, each cycle SHALL compute EXP_PER_CYCLE words W[t] for t = cnt .. cnt+EXP_PER_CYCLE-1.
REQ-015 Each computed word SHALL be W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], modulo 2^32, with carries discarded.
REQ-016 s0 SHALL be ROTR7 ^ ROTR18 ^ SHR3 and s1 SHALL be ROTR17 ^ ROTR19 ^ SHR10, using the team's sigma_functions package lower-sigma functions.
REQ-017 When EXP_PER_CYCLE > 1, words computed in the same cycle SHALL use the same-cycle combinational results of earlier words, not stale register values.
REQ-018 The counter SHALL advance by EXP_PER_CYCLE each EXPAND cycle; once W63 is written, the FSM SHALL enter DONE.
REQ-019 Latency SHALL be exactly 48/EXP_PER_CYCLE cycles from the accept edge to the first cycle with out_valid=1 (48 cycles at the default).
REQ-020 out_valid SHALL be 1 only in DONE.
REQ-021 message_schedule SHALL be held unchanged while out_valid=1, for any length of out_ready low.
REQ-022 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE on the next edge.
REQ-023 In DONE with out_ready=1 and in_valid=1, the handoff and the new accept SHALL occur on the same edge, the FSM SHALL go to EXPAND, and no bubble cycle SHALL be inserted.
REQ-024 in_valid asserted while in EXPAND, or in DONE with out_ready=0, SHALL be ignored with no state change.
REQ-025 In IDLE and EXPAND, message_schedule SHALL show the register contents; downstream SHALL qualify it only with out_valid.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-027 While rst=1, the block SHALL immediately and asynchronously force state=IDLE, counter=0, all 64 schedule words=0, out_valid=0 and in_ready=1.
REQ-028 Reset asserted mid-EXPAND SHALL abandon the block; after rst deasserts, out_valid SHALL stay 0 until a new block is accepted and fully expanded.
REQ-029 The first accept edge SHALL be the first clk edge with rst=0, in_valid=1 and in_ready=1.

Verification
REQ-030 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), EXP_PER_CYCLE=1 -> out_valid rises exactly 48 cycles after accept; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; W20..W63 match the software reference model.
REQ-031 All-zero block -> all 64 words are 0x00000000 and out_valid rises after 48 cycles.
REQ-032 Backpressure: out_ready held 0 for 20 cycles in DONE -> out_valid stays 1, message_schedule is bit-stable, and in_ready=0 throughout.
REQ-033 Back-to-back: second block presented with in_valid=1 in the same cycle out_ready=1 in DONE -> second accept on that edge, and second out_valid exactly 48 cycles later.
REQ-034 Reset pulse at cycle 20 of EXPAND -> out_valid=0, all words read 0, in_ready=1 during reset; no stray out_valid afterwards.
REQ-035 EXP_PER_CYCLE=4 with the "abc" block -> out_valid after 12 cycles and schedule identical to REQ-030.
